// File: rtl/one_unit_pkg.sv
// one_unit_pkg -- definitions shared by the one_unit datapath blocks
// (the multiply stage and the accumulate/update stage).
//   DATA_W / FRAC_W : Q13 sample and weight format (26 bits, 13 fractional)
//   ACC_W           : accumulator width, wide enough for 4096 full-scale samples
//   SAT_MAX/SAT_MIN : clipping limits of a 26-bit signed result
//   acc_state_t     : state encoding of the accumulate/update FSM
package one_unit_pkg;

    localparam int DATA_W = 26;
    localparam int FRAC_W = 13;
    localparam int ACC_W  = 40;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd33554431;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd33554432;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACC   = 2'd1,
        ST_FINAL = 2'd2,
        ST_DONE  = 2'd3
    } acc_state_t;

    // Sign-extend one Q13 data word to accumulator width.
    function automatic logic signed [ACC_W-1:0] sext_data(input logic signed [DATA_W-1:0] d);
        return {{(ACC_W-DATA_W){d[DATA_W-1]}}, d};
    endfunction

endpackage

// File: rtl/one_unit_acc_lane.sv
// one_unit_acc_lane -- one lane of the averaging weight update.
// Holds the lane accumulator, the weight latched at start, and the
// registered new weight. Result = sat((acc >>> LOG_N) - 3*w_latched).
// Ports:
//   clk_acc, rst_acc : clock, asynchronous active-high reset
//   i_clear          : clear accumulator and latch i_w (start accepted)
//   i_w              : current weight, Q13
//   i_acc_en         : add i_d into the accumulator this cycle
//   i_d              : sample, Q13
//   i_final          : register the saturated result into o_wn
//   o_wn             : new weight, held until the next i_final
//   o_clip           : combinational, result currently needs clipping
module one_unit_acc_lane
    import one_unit_pkg::*;
#(
    parameter int LOG_N = 10
) (
    input  logic                     clk_acc,
    input  logic                     rst_acc,
    input  logic                     i_clear,
    input  logic signed [DATA_W-1:0] i_w,
    input  logic                     i_acc_en,
    input  logic signed [DATA_W-1:0] i_d,
    input  logic                     i_final,
    output logic signed [DATA_W-1:0] o_wn,
    output logic                     o_clip
);

    localparam logic signed [DATA_W-1:0] MAX_OUT = SAT_MAX[DATA_W-1:0];
    localparam logic signed [DATA_W-1:0] MIN_OUT = SAT_MIN[DATA_W-1:0];

    logic signed [ACC_W-1:0]  r_acc;
    logic signed [DATA_W-1:0] r_w;
    logic signed [DATA_W-1:0] r_wn;

    logic signed [ACC_W-1:0]  w_mean;
    logic signed [ACC_W-1:0]  w_w_ext;
    logic signed [ACC_W-1:0]  w_w3;
    logic signed [ACC_W-1:0]  w_diff;
    logic signed [DATA_W-1:0] w_sat;
    logic                     w_hi;
    logic                     w_lo;

    // Arithmetic shift gives the floor of the mean, also for negative sums.
    assign w_mean  = r_acc >>> LOG_N;
    assign w_w_ext = sext_data(r_w);
    assign w_w3    = (w_w_ext <<< 1) + w_w_ext;
    assign w_diff  = w_mean - w_w3;

    assign w_hi   = (w_diff > SAT_MAX);
    assign w_lo   = (w_diff < SAT_MIN);
    assign o_clip = w_hi | w_lo;
    assign w_sat  = w_hi ? MAX_OUT : (w_lo ? MIN_OUT : w_diff[DATA_W-1:0]);

    always_ff @(posedge clk_acc or posedge rst_acc) begin
        if (rst_acc) begin
            r_acc <= '0;
            r_w   <= '0;
            r_wn  <= '0;
        end else begin
            if (i_clear) begin
                r_acc <= '0;
                r_w   <= i_w;
            end else if (i_acc_en) begin
                r_acc <= r_acc + sext_data(i_d);
            end
            if (i_final) begin
                r_wn <= w_sat;
            end
        end
    end

    assign o_wn = r_wn;

endmodule

// File: rtl/one_unit_acc4.sv
// one_unit_acc4 -- averages N = 2^LOG_N four-lane samples and produces the
// updated weight vector wn = sat(mean(d) - 3*w).
// Ports:
//   clk_acc, rst_acc : clock, asynchronous active-high reset
//   start            : begins an iteration (sampled only in IDLE)
//   w1..w4           : weight vector, latched on start
//   in_valid, d1..d4 : sample stream (accepted only in ACC)
//   busy             : high in every state except IDLE
//   out_valid        : one-cycle pulse (DONE) marking wn1..wn4 updated
//   wn1..wn4         : new weights, held between updates
//   sat              : some lane clipped in the last update
module one_unit_acc4
    import one_unit_pkg::*;
#(
    parameter int LOG_N = 10
) (
    input  logic                     clk_acc,
    input  logic                     rst_acc,
    input  logic                     start,
    input  logic signed [DATA_W-1:0] w1,
    input  logic signed [DATA_W-1:0] w2,
    input  logic signed [DATA_W-1:0] w3,
    input  logic signed [DATA_W-1:0] w4,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] d1,
    input  logic signed [DATA_W-1:0] d2,
    input  logic signed [DATA_W-1:0] d3,
    input  logic signed [DATA_W-1:0] d4,
    output logic                     busy,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] wn1,
    output logic signed [DATA_W-1:0] wn2,
    output logic signed [DATA_W-1:0] wn3,
    output logic signed [DATA_W-1:0] wn4,
    output logic                     sat
);

    acc_state_t       r_state;
    logic [LOG_N-1:0] r_cnt;
    logic             r_busy;
    logic             r_out_valid;
    logic             r_sat;

    logic                     w_clear;
    logic                     w_acc_en;
    logic                     w_final;
    logic [3:0]               w_clip;
    logic signed [DATA_W-1:0] w_w  [4];
    logic signed [DATA_W-1:0] w_d  [4];
    logic signed [DATA_W-1:0] w_wn [4];

    assign w_w[0] = w1;
    assign w_w[1] = w2;
    assign w_w[2] = w3;
    assign w_w[3] = w4;
    assign w_d[0] = d1;
    assign w_d[1] = d2;
    assign w_d[2] = d3;
    assign w_d[3] = d4;

    assign w_clear  = (r_state == ST_IDLE) && start;
    assign w_acc_en = (r_state == ST_ACC) && in_valid;
    assign w_final  = (r_state == ST_FINAL);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            one_unit_acc_lane #(.LOG_N(LOG_N)) u_lane (
                .clk_acc  (clk_acc),
                .rst_acc  (rst_acc),
                .i_clear  (w_clear),
                .i_w      (w_w[gi]),
                .i_acc_en (w_acc_en),
                .i_d      (w_d[gi]),
                .i_final  (w_final),
                .o_wn     (w_wn[gi]),
                .o_clip   (w_clip[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk_acc or posedge rst_acc) begin
        if (rst_acc) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_sat       <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_cnt   <= '0;
                        r_sat   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= ST_ACC;
                    end
                end
                ST_ACC: begin
                    if (in_valid) begin
                        r_cnt <= r_cnt + LOG_N'(1);
                        // Counter is all ones exactly at sample N-1.
                        if (&r_cnt) begin
                            r_state <= ST_FINAL;
                        end
                    end
                end
                ST_FINAL: begin
                    r_sat       <= |w_clip;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign out_valid = r_out_valid;
    assign sat       = r_sat;
    assign wn1       = w_wn[0];
    assign wn2       = w_wn[1];
    assign wn3       = w_wn[2];
    assign wn4       = w_wn[3];

endmodule

// File: tb/tb_one_unit_acc4.sv
module tb_one_unit_acc4;

    localparam int LOG_N = 2;
    localparam int NS    = 1 << LOG_N;

    logic clk_acc = 1'b0;
    logic rst_acc = 1'b1;
    logic start = 1'b0;
    logic in_valid = 1'b0;
    logic signed [25:0] w1 = '0, w2 = '0, w3 = '0, w4 = '0;
    logic signed [25:0] d1 = '0, d2 = '0, d3 = '0, d4 = '0;
    logic busy, out_valid, sat;
    logic signed [25:0] wn1, wn2, wn3, wn4;

    one_unit_acc4 #(.LOG_N(LOG_N)) dut (
        .clk_acc(clk_acc), .rst_acc(rst_acc), .start(start),
        .w1(w1), .w2(w2), .w3(w3), .w4(w4),
        .in_valid(in_valid), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .busy(busy), .out_valid(out_valid),
        .wn1(wn1), .wn2(wn2), .wn3(wn3), .wn4(wn4), .sat(sat)
    );

    always #5 clk_acc = ~clk_acc;

    int checks = 0;
    int errors = 0;

    // Stimulus of one iteration: weights and NS samples per lane.
    int w_cur [4];
    int samp  [NS][4];
    logic signed [25:0] exp_wn [4];
    logic exp_sat;
    logic signed [25:0] wn_a [4];

    assign wn_a[0] = wn1;
    assign wn_a[1] = wn2;
    assign wn_a[2] = wn3;
    assign wn_a[3] = wn4;

    task automatic chk(input string tag, input longint obs, input longint expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int rnd26();
        logic [25:0] t;
        t = 26'($urandom);
        return int'($signed(t));
    endfunction

    // Reference: floor of the integer mean, minus three times the weight,
    // clipped to the 26-bit signed range.
    task automatic model();
        longint sum, q, r;
        exp_sat = 1'b0;
        for (int k = 0; k < 4; k++) begin
            sum = 0;
            for (int s = 0; s < NS; s++) sum += samp[s][k];
            q = sum / NS;
            if ((sum % NS != 0) && (sum < 0)) q = q - 1;
            r = q - 3 * longint'(w_cur[k]);
            if (r > 33554431) begin r = 33554431; exp_sat = 1'b1; end
            if (r < -33554432) begin r = -33554432; exp_sat = 1'b1; end
            exp_wn[k] = 26'(r);
        end
    endtask

    task automatic set_d(input int s);
        d1 = samp[s][0][25:0];
        d2 = samp[s][1][25:0];
        d3 = samp[s][2][25:0];
        d4 = samp[s][3][25:0];
    endtask

    task automatic junk_inputs();
        d1 = 26'($urandom); d2 = 26'($urandom);
        d3 = 26'($urandom); d4 = 26'($urandom);
    endtask

    // Start accepted at the following edge; weights scrambled afterwards.
    task automatic start_iter();
        @(negedge clk_acc);
        w1 = w_cur[0][25:0]; w2 = w_cur[1][25:0];
        w3 = w_cur[2][25:0]; w4 = w_cur[3][25:0];
        start = 1'b1;
        @(negedge clk_acc);
        start = 1'b0;
        w1 = 26'($urandom); w2 = 26'($urandom);
        w3 = 26'($urandom); w4 = 26'($urandom);
        chk("busy_after_start", longint'(busy), 1);
    endtask

    task automatic send(input int s, input int gap, input bit noise);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            start = noise;
            junk_inputs();
            @(negedge clk_acc);
        end
        start = 1'b0;
        in_valid = 1'b1;
        set_d(s);
        @(negedge clk_acc);
        in_valid = 1'b0;
    endtask

    task automatic run_iter(input string tag, input int maxgap, input bit noise);
        model();
        start_iter();
        for (int s = 0; s < NS; s++) send(s, $urandom_range(0, maxgap), noise);
        // FINAL: in_valid noise must be ignored
        in_valid = noise;
        junk_inputs();
        chk({tag, "_ov_final"}, longint'(out_valid), 0);
        chk({tag, "_busy_final"}, longint'(busy), 1);
        @(negedge clk_acc);
        // DONE: results visible with the pulse; start here is ignored
        start = noise;
        chk({tag, "_ov_done"}, longint'(out_valid), 1);
        chk({tag, "_busy_done"}, longint'(busy), 1);
        for (int k = 0; k < 4; k++) chk($sformatf("%s_wn%0d", tag, k + 1), longint'(wn_a[k]), longint'(exp_wn[k]));
        chk({tag, "_sat"}, longint'(sat), longint'(exp_sat));
        @(negedge clk_acc);
        start = 1'b0;
        chk({tag, "_ov_idle"}, longint'(out_valid), 0);
        chk({tag, "_busy_idle"}, longint'(busy), 0);
        @(negedge clk_acc);
        in_valid = 1'b0;
        chk({tag, "_busy_stay_idle"}, longint'(busy), 0);
        chk({tag, "_wn1_hold"}, longint'(wn1), longint'(exp_wn[0]));
        chk({tag, "_sat_hold"}, longint'(sat), longint'(exp_sat));
    endtask

    task automatic fill(input int wv, input int dv);
        for (int k = 0; k < 4; k++) begin
            w_cur[k] = wv;
            for (int s = 0; s < NS; s++) samp[s][k] = dv;
        end
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_ov", longint'(out_valid), 0);
        chk("rst_sat", longint'(sat), 0);
        chk("rst_wn1", longint'(wn1), 0);
        chk("rst_wn4", longint'(wn4), 0);
        @(negedge clk_acc);
        rst_acc = 1'b0;

        fill(0, 8192);            run_iter("basic", 0, 1'b0);
        fill(8192, 8192);         run_iter("wsub", 0, 1'b0);
        fill(8192, 8192);         run_iter("wsub_gaps", 3, 1'b0);
        fill(-33554432, 33554431); run_iter("clip_hi", 0, 1'b0);
        fill(0, 0);               run_iter("clip_clear", 1, 1'b0);
        fill(0, -1);              run_iter("floor", 0, 1'b0);
        fill(0, 0);
        for (int s = 0; s < NS; s++) begin
            samp[s][0] = 4 * 8192; samp[s][1] = 8 * 8192;
            samp[s][2] = 12 * 8192; samp[s][3] = -16 * 8192;
        end
        run_iter("lanes", 2, 1'b0);

        // Reset in the middle of ACC: no pulse, clean restart afterwards
        fill(0, 8192);
        start_iter();
        send(0, 0, 1'b0);
        send(1, 0, 1'b0);
        #2 rst_acc = 1'b1;
        #1;
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_wn1", longint'(wn1), 0);
        chk("midrst_sat", longint'(sat), 0);
        @(negedge clk_acc);
        rst_acc = 1'b0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            @(negedge clk_acc);
            chk("midrst_no_ov", longint'(out_valid), 0);
        end
        in_valid = 1'b0;
        fill(0, 8192);            run_iter("after_rst", 1, 1'b1);

        // Start and in_valid noise outside their states
        fill(8192, 8192);         run_iter("noise", 3, 1'b1);

        // Random iterations
        for (int it = 0; it < 20; it++) begin
            for (int k = 0; k < 4; k++) begin
                w_cur[k] = ($urandom_range(0, 3) == 0) ? -33554432 : rnd26() >>> $urandom_range(0, 12);
                for (int s = 0; s < NS; s++)
                    samp[s][k] = ($urandom_range(0, 5) == 0) ? 33554431 : rnd26();
            end
            run_iter($sformatf("rnd%0d", it), 3, it[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
